video_cropper: RTL and testbench

VIDEO_CROPPER -- requirements
Module: video_cropper

---
 rtl/video_cropper_pkg.sv | 39 +++
 rtl/video_cropper_if.sv | 14 +
 rtl/video_pos_counter.sv | 55 +++++
 rtl/video_cropper.sv | 133 +++++++++++++
 tb/tb_video_cropper.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/video_cropper_pkg.sv
// Shared definitions for the DVP/VP video blocks.
//   COORD_W    : width of pixel/line coordinates and counters
//   PIX_W      : width of an RGB888 pixel
//   PIX_BLACK  : value driven on the pixel bus outside active data
//   crop_state_e : cropper line-tracking FSM encodings
//   sat_inc    : saturating coordinate increment
//   in_span    : start <= pos < start+size, widened so start+size cannot wrap
package video_cropper_pkg;

  localparam int COORD_W = 12;
  localparam int PIX_W   = 24;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0]   pix_t;

  localparam pix_t   PIX_BLACK = 24'h000000;
  localparam coord_t COORD_MAX = '1;

  typedef enum logic [1:0] {
    FRAME_WAIT = 2'd0,
    LINE_WAIT  = 2'd1,
    IN_LINE    = 2'd2
  } crop_state_e;

  function automatic coord_t sat_inc(coord_t v);
    return (v == COORD_MAX) ? v : v + coord_t'(1);
  endfunction

  function automatic logic in_span(coord_t pos, coord_t start, coord_t size);
    logic [COORD_W:0] pos_w;
    logic [COORD_W:0] lo_w;
    logic [COORD_W:0] hi_w;
    pos_w = {1'b0, pos};
    lo_w  = {1'b0, start};
    hi_w  = {1'b0, start} + {1'b0, size};
    return (pos_w >= lo_w) && (pos_w < hi_w);
  endfunction

endpackage

// File: rtl/video_cropper_if.sv
// Parallel video stream bundle (vsync, data enable, RGB888 pixel).
//   master : drives vs/de/data
//   slave  : receives vs/de/data
interface video_cropper_if;
  import video_cropper_pkg::*;

  logic vs;
  logic de;
  pix_t data;

  modport master (output vs, de, data);
  modport slave  (input  vs, de, data);

endinterface

// File: rtl/video_pos_counter.sv
// Pixel/line position counters for a DE/VS video stream.
//   clk, rst_n : pixel clock, async active-low reset
//   en         : counters run when 1, held at 0 when 0
//   vs, de     : input vertical sync and data enable
//   hcnt       : pixel index within the current line (saturates at max)
//   vcnt       : line index within the current frame (saturates at max)
module video_pos_counter
  import video_cropper_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   vs,
  input  logic   de,
  output coord_t hcnt,
  output coord_t vcnt
);

  coord_t hcnt_q, hcnt_d;
  coord_t vcnt_q, vcnt_d;
  logic   de_q, de_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    de_d   = de;
    if (!en || vs) begin
      hcnt_d = '0;
      vcnt_d = '0;
      de_d   = 1'b0;
    end else if (de) begin
      hcnt_d = sat_inc(hcnt_q);
    end else if (de_q) begin
      // falling edge of DE closes the line
      hcnt_d = '0;
      vcnt_d = sat_inc(vcnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      de_q   <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      de_q   <= de_d;
    end
  end

  assign hcnt = hcnt_q;
  assign vcnt = vcnt_q;

endmodule

// File: rtl/video_cropper.sv
// Rectangular window cropper for a DE/VS video stream, 1-clock latency.
//   clk, rst_n       : pixel clock, async active-low reset
//   EN               : crop enable (0 = transparent bypass)
//   x_start, y_start : window origin (pixel / line index, 0-based)
//   crop_w, crop_h   : window size in pixels / lines
//   pre              : input stream (slave)
//   post             : output stream (master); data is black outside the window
// Geometry and enable are sampled into shadows while vsync is high, so
// changes made mid-frame apply from the next frame on.
//
// state      | meaning
// FRAME_WAIT | in vsync or first cycle after it; nothing is output
// LINE_WAIT  | horizontal blanking, waiting for DE
// IN_LINE    | active pixels of a line
module video_cropper
  import video_cropper_pkg::*;
#(
  parameter coord_t H_DISP = 12'd1280,
  parameter coord_t V_DISP = 12'd720
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EN,
  input  coord_t          x_start,
  input  coord_t          y_start,
  input  coord_t          crop_w,
  input  coord_t          crop_h,
  video_cropper_if.slave  pre,
  video_cropper_if.master post
);

  crop_state_e state_q, state_d;

  logic   en_f_q, en_f_d;
  coord_t x_start_q, x_start_d;
  coord_t y_start_q, y_start_d;
  coord_t crop_w_q, crop_w_d;
  coord_t crop_h_q, crop_h_d;

  logic   post_vs_q, post_vs_d;
  logic   post_de_q, post_de_d;
  pix_t   post_data_q, post_data_d;

  coord_t hcnt, vcnt;
  logic   in_win;

  video_pos_counter u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_f_q),
    .vs    (pre.vs),
    .de    (pre.de),
    .hcnt  (hcnt),
    .vcnt  (vcnt)
  );

  always_comb begin
    en_f_d    = en_f_q;
    x_start_d = x_start_q;
    y_start_d = y_start_q;
    crop_w_d  = crop_w_q;
    crop_h_d  = crop_h_q;
    if (pre.vs) begin
      en_f_d    = EN;
      x_start_d = x_start;
      y_start_d = y_start;
      crop_w_d  = crop_w;
      crop_h_d  = crop_h;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pre.vs) begin
      state_d = FRAME_WAIT;
    end else begin
      unique case (state_q)
        FRAME_WAIT: state_d = LINE_WAIT;
        LINE_WAIT:  if (pre.de)  state_d = IN_LINE;
        IN_LINE:    if (!pre.de) state_d = LINE_WAIT;
        default:    state_d = FRAME_WAIT;
      endcase
    end
  end

  // vsync is excluded directly so an abort mid-line blanks the very next
  // output, before the FSM register has seen it. Positions beyond the
  // supported display size are never treated as in-window.
  assign in_win = pre.de && !pre.vs && (state_q != FRAME_WAIT)
               && in_span(hcnt, x_start_q, crop_w_q)
               && in_span(vcnt, y_start_q, crop_h_q)
               && (hcnt < H_DISP) && (vcnt < V_DISP);

  always_comb begin
    post_vs_d = pre.vs;
    if (!en_f_q) begin
      post_de_d   = pre.de;
      post_data_d = pre.data;
    end else begin
      post_de_d   = in_win;
      post_data_d = in_win ? pre.data : PIX_BLACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FRAME_WAIT;
      en_f_q      <= 1'b0;
      x_start_q   <= '0;
      y_start_q   <= '0;
      crop_w_q    <= '0;
      crop_h_q    <= '0;
      post_vs_q   <= 1'b0;
      post_de_q   <= 1'b0;
      post_data_q <= PIX_BLACK;
    end else begin
      state_q     <= state_d;
      en_f_q      <= en_f_d;
      x_start_q   <= x_start_d;
      y_start_q   <= y_start_d;
      crop_w_q    <= crop_w_d;
      crop_h_q    <= crop_h_d;
      post_vs_q   <= post_vs_d;
      post_de_q   <= post_de_d;
      post_data_q <= post_data_d;
    end
  end

  assign post.vs   = post_vs_q;
  assign post.de   = post_de_q;
  assign post.data = post_data_q;

endmodule

// File: tb/tb_video_cropper.sv
module tb_video_cropper;
  import video_cropper_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] xs = '0, ys = '0, cw = '0, ch = '0;

  video_cropper_if pre_if ();
  video_cropper_if post_if ();

  video_cropper dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .EN      (en),
    .x_start (xs),
    .y_start (ys),
    .crop_w  (cw),
    .crop_h  (ch),
    .pre     (pre_if),
    .post    (post_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: shadowed config plus pixel/line position in the frame
  bit m_en = 0;
  int m_xs = 0, m_ys = 0, m_w = 0, m_h = 0;
  int m_x = 0, m_y = 0;
  bit m_prev_de = 0, m_prev_vs = 0;

  int out_cnt = 0;
  longint out_sum = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_xs = 0; m_ys = 0; m_w = 0; m_h = 0;
    m_x = 0; m_y = 0; m_prev_de = 0; m_prev_vs = 0;
  endtask

  // one pixel clock: drive inputs, predict, sample 1 clock later, advance model
  task automatic tick(input bit vs, input bit de, input logic [23:0] d);
    bit          e_de;
    logic [23:0] e_data;
    bit          win;
    pre_if.vs = vs; pre_if.de = de; pre_if.data = d;
    if (!m_en) begin
      e_de = de; e_data = d;
    end else begin
      // first cycle after vsync is still frame blanking
      win = de && !vs && !m_prev_vs
            && m_x >= m_xs && m_x < m_xs + m_w
            && m_y >= m_ys && m_y < m_ys + m_h
            && m_x < 1280 && m_y < 720;
      e_de = win;
      e_data = win ? d : 24'h0;
    end
    @(posedge clk); #1;
    check("post_vs", post_if.vs, vs);
    check("post_de", post_if.de, e_de);
    check("post_data", post_if.data, e_data);
    if (post_if.de) begin
      out_cnt++;
      out_sum += post_if.data;
    end
    if (vs) begin
      m_en = en; m_xs = xs; m_ys = ys; m_w = cw; m_h = ch;
      m_x = 0; m_y = 0; m_prev_de = 0;
    end else if (!m_en) begin
      m_x = 0; m_y = 0; m_prev_de = 0;
    end else if (de) begin
      m_x++; m_prev_de = 1;
    end else begin
      if (m_prev_de) begin
        m_x = 0; m_y++;
      end
      m_prev_de = 0;
    end
    m_prev_vs = vs;
  endtask

  // vsync, blanking, then `lines` lines of `pix` pixels; optional x_start change
  task automatic frame(input int lines, input int pix, input bit idx_data,
                       input int chg_line = -1, input logic [11:0] chg_xs = 0);
    out_cnt = 0; out_sum = 0;
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick(1, 0, 24'($urandom));
    for (int i = 0; i < 2; i++) tick(0, 0, 24'($urandom));
    for (int l = 0; l < lines; l++) begin
      if (l == chg_line) xs = chg_xs;
      for (int p = 0; p < pix; p++) tick(0, 1, idx_data ? 24'(p) : 24'($urandom));
      for (int i = 0; i < int'($urandom_range(2, 6)); i++) tick(0, 0, 24'($urandom));
    end
  endtask

  initial begin
    pre_if.vs = 0; pre_if.de = 0; pre_if.data = '0;
    #1;
    check("rst_post_vs", post_if.vs, 0);
    check("rst_post_de", post_if.de, 0);
    check("rst_post_data", post_if.data, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // bypass before the first vsync, even with EN requested
    en = 1;
    for (int i = 0; i < 10; i++) tick(0, 1'($urandom), 24'($urandom));

    // small window on 3 lines of 8 pixels
    xs = 2; ys = 1; cw = 4; ch = 2;
    frame(3, 8, 1);
    check("win_count", out_cnt, 8);
    check("win_sum", 32'(out_sum), 28);

    // bypass, bit-exact
    en = 0;
    frame(24, 64, 0);
    check("bypass_count", out_cnt, 24 * 64);

    // window running past the end of 1280-pixel lines
    en = 1; xs = 1276; cw = 100; ys = 0; ch = 2;
    frame(2, 1280, 1);
    check("clip_count", out_cnt, 8);
    check("clip_sum", 32'(out_sum), 2 * (1276 + 1277 + 1278 + 1279));

    // x_start changed mid-frame applies from the next frame
    xs = 0; cw = 4; ys = 0; ch = 1;
    frame(2, 16, 1, 1, 12'd10);
    check("chg_cur_sum", 32'(out_sum), 0 + 1 + 2 + 3);
    frame(2, 16, 1);
    check("chg_next_sum", 32'(out_sum), 10 + 11 + 12 + 13);

    // zero-height window
    xs = 0; cw = 8; ch = 0;
    frame(4, 16, 0);
    check("h0_count", out_cnt, 0);

    // randomized geometry and enable
    for (int f = 0; f < 8; f++) begin
      en = 1'($urandom_range(0, 1));
      xs = 12'($urandom_range(0, 40)); cw = 12'($urandom_range(0, 40));
      ys = 12'($urandom_range(0, 6));  ch = 12'($urandom_range(0, 6));
      frame($urandom_range(1, 8), $urandom_range(1, 60), 0);
    end

    // vsync on the 3rd in-window pixel, then reset mid-line
    en = 1; xs = 2; cw = 8; ys = 0; ch = 4;
    frame(0, 0, 1);
    for (int p = 0; p < 4; p++) tick(0, 1, 24'hA50000 | 24'(p));
    tick(1, 1, 24'hA50004);
    check("abort_de", post_if.de, 0);
    for (int p = 0; p < 4; p++) tick(0, 1, 24'hA50010 | 24'(p));
    check("pre_rst_de", post_if.de, 1);
    rst_n = 0;
    #1;
    check("async_rst_data", post_if.data, 0);
    check("async_rst_de", post_if.de, 0);
    check("async_rst_state", 32'(dut.state_q), 32'(FRAME_WAIT));
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 12; i++) tick(0, 1'($urandom), 24'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
